glenn_uart_rx: RTL and testbench



---
 rtl/glenn_uart_rx.sv | 193 +++++++++++++++++++
 tb/tb_glenn_uart_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/glenn_uart_rx.sv
// glenn_uart_rx: 8N1 UART receiver (optional even parity via UART_RX_PARITY_EN)
// Ports: in_UART_Clock, in_RST (sync, active-high), in_Rx_Serial;
//   out_Rx_8bitData, out_Rx_Done, out_Rx_Active, out_Rx_Frame_Error,
//   out_Rx_Parity_Error, out_Rx_Frame_Count
module glenn_uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       in_UART_Clock,
  input  logic       in_RST,
  input  logic       in_Rx_Serial,
  output logic [7:0] out_Rx_8bitData,
  output logic       out_Rx_Done,
  output logic       out_Rx_Active,
  output logic       out_Rx_Frame_Error,
  output logic       out_Rx_Parity_Error,
  output logic [7:0] out_Rx_Frame_Count
);

  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  logic       rx_m;
  logic       rx_s;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       ferr_q, ferr_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       bit_end;
`ifdef UART_RX_PARITY_EN
  logic       pbad_q, pbad_d;
  logic       perr_q, perr_d;
`endif

  // cnt counts cycles since the previous sample point
  assign bit_end = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    fcnt_d  = fcnt_q;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          idx_d = 3'd0;
          // HALF==0: the start sample is t0 itself
          if (HALF == 8'd0) begin
            state_d = S_DATA;
            cnt_d   = 8'd0;
          end else begin
            state_d = S_START;
            cnt_d   = 8'd1;
          end
        end
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d = 8'd0;
          if (rx_s) state_d = S_IDLE;
          else      state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = 8'd0;
          sr_d  = {rx_s, sr_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = 8'd0;
          pbad_d  = rx_s ^ (^sr_q);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d = 8'd0;
          if (!rx_s) begin
            ferr_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = pbad_q;
`endif
            state_d = S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          end else if (pbad_q) begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            done_d  = 1'b1;
            data_d  = sr_q;
            fcnt_d  = fcnt_q + 8'd1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // a held-low line (break) must not look like a new start bit
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_UART_Clock) begin
    if (in_RST) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      sr_q    <= 8'd0;
      data_q  <= 8'd0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      fcnt_q  <= 8'd0;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      rx_m    <= in_Rx_Serial;
      rx_s    <= rx_m;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      fcnt_q  <= fcnt_d;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= pbad_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign out_Rx_8bitData    = data_q;
  assign out_Rx_Done        = done_q;
  assign out_Rx_Frame_Error = ferr_q;
  assign out_Rx_Frame_Count = fcnt_q;
  assign out_Rx_Active      = (state_q != S_IDLE) &&
                              (state_q != S_WAIT_HIGH);
`ifdef UART_RX_PARITY_EN
  assign out_Rx_Parity_Error = perr_q;
`else
  assign out_Rx_Parity_Error = 1'b0;
`endif

endmodule

// File: tb/tb_glenn_uart_rx.sv
// tb_glenn_uart_rx: directed bench for glenn_uart_rx
// Two instances: CLKS_PER_BIT=1 (u1) and CLKS_PER_BIT=16 (u16)
module tb_glenn_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx1 = 1'b1;
  logic       rx16 = 1'b1;

  logic [7:0] data1, cnt1, data16, cnt16;
  logic       done1, act1, ferr1, perr1;
  logic       done16, act16, ferr16, perr16;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc1 = 0;
  int done_cyc16 = 0;
  int n_done1 = 0, n_ferr1 = 0, n_perr1 = 0;
  int n_done16 = 0, n_ferr16 = 0, n_perr16 = 0;
  logic [7:0] got1[$];

`ifdef UART_RX_PARITY_EN
  localparam int LAT1  = 13;
  localparam int LAT16 = 170;
`else
  localparam int LAT1  = 12;
  localparam int LAT16 = 154;
`endif

  glenn_uart_rx #(.CLKS_PER_BIT(1)) u1 (
    .in_UART_Clock       (clk),
    .in_RST              (rst),
    .in_Rx_Serial        (rx1),
    .out_Rx_8bitData     (data1),
    .out_Rx_Done         (done1),
    .out_Rx_Active       (act1),
    .out_Rx_Frame_Error  (ferr1),
    .out_Rx_Parity_Error (perr1),
    .out_Rx_Frame_Count  (cnt1)
  );

  glenn_uart_rx #(.CLKS_PER_BIT(16)) u16 (
    .in_UART_Clock       (clk),
    .in_RST              (rst),
    .in_Rx_Serial        (rx16),
    .out_Rx_8bitData     (data16),
    .out_Rx_Done         (done16),
    .out_Rx_Active       (act16),
    .out_Rx_Frame_Error  (ferr16),
    .out_Rx_Parity_Error (perr16),
    .out_Rx_Frame_Count  (cnt16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done1) begin
      n_done1++;
      done_cyc1 = cyc;
      got1.push_back(data1);
    end
    if (ferr1) n_ferr1++;
    if (perr1) n_perr1++;
    if (done16) begin
      n_done16++;
      done_cyc16 = cyc;
    end
    if (ferr16) n_ferr16++;
    if (perr16) n_perr16++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  // drive one frame; line is left low afterwards if stop==0
  task automatic send(input bit fast,
                      input logic [7:0] b,
                      input logic stop,
                      input logic pflip);
    logic [10:0] fr;
    int n;
    int cpb;
    cpb = fast ? 1 : 16;
`ifdef UART_RX_PARITY_EN
    fr = {stop, (^b) ^ pflip, b, 1'b0};
    n  = 11;
`else
    fr = {pflip, stop, b, 1'b0};
    n  = 10;
`endif
    start_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      if (fast) rx1 = fr[i];
      else      rx16 = fr[i];
      repeat (cpb) tick();
    end
    if (stop) begin
      if (fast) rx1 = 1'b1;
      else      rx16 = 1'b1;
    end
    repeat (2) tick();
  endtask

  initial begin
    logic [3:0] part;
    repeat (3) tick();
    chk("rst_data16", 32'(data16), 32'h00);
    chk("rst_cnt16", 32'(cnt16), 32'h00);
    chk("rst_act16", 32'(act16), 32'h0);
    chk("rst_done16", 32'(done16), 32'h0);
    chk("rst_ferr16", 32'(ferr16), 32'h0);
    chk("rst_data1", 32'(data1), 32'h00);
    rst = 1'b0;
    repeat (3) tick();

    // back-to-back at one clock per bit
    send(1'b1, 8'hA5, 1'b1, 1'b0);
    send(1'b1, 8'h5A, 1'b1, 1'b0);
    repeat (2) tick();
    chk("b2b_ndone", 32'(n_done1), 32'd2);
    chk("b2b_first", 32'(got1[0]), 32'hA5);
    chk("b2b_second", 32'(got1[1]), 32'h5A);
    chk("b2b_data", 32'(data1), 32'h5A);
    chk("b2b_cnt", 32'(cnt1), 32'd2);
    chk("lat1", 32'(done_cyc1 - start_cyc), 32'(LAT1));

    // 254 more frames: count wraps to 0
    for (int i = 0; i < 254; i++)
      send(1'b1, 8'(i), 1'b1, 1'b0);
    repeat (2) tick();
    chk("wrap_cnt", 32'(cnt1), 32'd0);
    chk("wrap_ndone", 32'(n_done1), 32'd256);
    chk("wrap_data", 32'(data1), 32'hFD);

    // 16 clocks per bit
    send(1'b0, 8'h3C, 1'b1, 1'b0);
    repeat (2) tick();
    chk("c16_ndone", 32'(n_done16), 32'd1);
    chk("c16_data", 32'(data16), 32'h3C);
    chk("c16_cnt", 32'(cnt16), 32'd1);
    chk("lat16", 32'(done_cyc16 - start_cyc), 32'(LAT16));

    // start glitch: 3 cycles low
    repeat (4) tick();
    rx16 = 1'b0;
    repeat (3) tick();
    rx16 = 1'b1;
    chk("gl_act_hi", 32'(act16), 32'h1);
    repeat (10) tick();
    chk("gl_act_lo", 32'(act16), 32'h0);
    chk("gl_ndone", 32'(n_done16), 32'd1);
    chk("gl_nferr", 32'(n_ferr16), 32'd0);
    chk("gl_data", 32'(data16), 32'h3C);

    // framing error, then line held low
    send(1'b0, 8'h55, 1'b0, 1'b0);
    repeat (40) tick();
    chk("fe_nferr", 32'(n_ferr16), 32'd1);
    chk("fe_act", 32'(act16), 32'h0);
    chk("fe_ndone", 32'(n_done16), 32'd1);
    chk("fe_data", 32'(data16), 32'h3C);
    chk("fe_cnt", 32'(cnt16), 32'd1);
    rx16 = 1'b1;
    repeat (4) tick();
    send(1'b0, 8'h11, 1'b1, 1'b0);
    repeat (2) tick();
    chk("fe_rec_ndone", 32'(n_done16), 32'd2);
    chk("fe_rec_data", 32'(data16), 32'h11);
    chk("fe_rec_cnt", 32'(cnt16), 32'd2);

    // reset after 4 data bits
    part = 4'b1010;
    rx16 = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 4; i++) begin
      rx16 = part[i];
      repeat (16) tick();
    end
    rst = 1'b1;
    tick();
    chk("mr_data", 32'(data16), 32'h00);
    chk("mr_cnt", 32'(cnt16), 32'd0);
    chk("mr_act", 32'(act16), 32'h0);
    chk("mr_done", 32'(done16), 32'h0);
    chk("mr_ferr", 32'(ferr16), 32'h0);
    rst = 1'b0;
    rx16 = 1'b1;
    repeat (30) tick();
    chk("mr_ndone", 32'(n_done16), 32'd2);
    chk("mr_nferr", 32'(n_ferr16), 32'd1);
    send(1'b0, 8'h81, 1'b1, 1'b0);
    repeat (2) tick();
    chk("mr_rec_data", 32'(data16), 32'h81);
    chk("mr_rec_cnt", 32'(cnt16), 32'd1);
    chk("mr_rec_ndone", 32'(n_done16), 32'd3);

`ifdef UART_RX_PARITY_EN
    send(1'b0, 8'h07, 1'b1, 1'b0);
    repeat (2) tick();
    chk("par_ok_ndone", 32'(n_done16), 32'd4);
    chk("par_ok_data", 32'(data16), 32'h07);
    chk("par_ok_nperr", 32'(n_perr16), 32'd0);
    send(1'b0, 8'h07, 1'b1, 1'b1);
    repeat (2) tick();
    chk("par_bad_nperr", 32'(n_perr16), 32'd1);
    chk("par_bad_ndone", 32'(n_done16), 32'd4);
    chk("par_bad_data", 32'(data16), 32'h07);
    chk("par_bad_cnt", 32'(cnt16), 32'd2);
    chk("par_bad_nferr", 32'(n_ferr16), 32'd1);
`else
    chk("nperr16", 32'(n_perr16), 32'd0);
    chk("nperr1", 32'(n_perr1), 32'd0);
`endif
    chk("nferr1", 32'(n_ferr1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
